// File: rtl/ddr_arb_pkg.sv
// Shared widths and the downstream arw payload type for the two-port DDR AXI arbiter.
package ddr_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 128;
   localparam int STRB_W = 16;
   localparam int UID_W  = 7;
   localparam int DID_W  = 8;
   localparam int LEN_W  = 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [1:0]        burst;
      logic [DID_W-1:0]  id;
      logic [LEN_W-1:0]  len;
      logic [1:0]        lock;
      logic [2:0]        size;
      logic              write;
   } arwPayload_t;

   // Downstream ID carries the source port in its MSB so responses can be routed back.
   function automatic logic [DID_W-1:0] makeDownId(input logic port, input logic [UID_W-1:0] uid);
      return {port, uid};
   endfunction

endpackage

// File: rtl/ddr_arb_wfifo.sv
// Write-order FIFO: holds {port, id} of accepted write bursts until their last W beat.
module ddr_arb_wfifo
   import ddr_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [DID_W-1:0] pushData,
   input  logic             pop,
   output logic [DID_W-1:0] headData,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DID_W-1:0] mem [DEPTH];
   logic [AW:0]      wrPtrReg;
   logic [AW:0]      rdPtrReg;
   logic             doPush;
   logic             doPop;

   assign doPush = push && !full;
   assign doPop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wrPtrReg <= '0;
         rdPtrReg <= '0;
      end else begin
         if (doPush) wrPtrReg <= wrPtrReg + (AW+1)'(1);
         if (doPop)  rdPtrReg <= rdPtrReg + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtrReg[AW-1:0]] <= pushData;
   end

   // Head is read combinationally so W forwarding adds no latency.
   assign headData = mem[rdPtrReg[AW-1:0]];
   assign empty    = (wrPtrReg == rdPtrReg);
   assign full     = (wrPtrReg[AW] != rdPtrReg[AW]) && (wrPtrReg[AW-1:0] == rdPtrReg[AW-1:0]);

endmodule

// File: rtl/ddr_axi_arbiter2.sv
// Two-master arbiter onto one DDR AXI port (combined arw channel, ordered W, ID-routed R/B).
// Build option: define DDR_ARB_FIXED_PRIO_EN for fixed port-0 priority with port-1 starvation guard.
module ddr_axi_arbiter2
   import ddr_arb_pkg::*;
#(
   parameter int WFIFO_DEPTH  = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              io_memoryClk,
   input  logic              memoryClk_rstn,

   input  logic              s0_arw_valid,
   output logic              s0_arw_ready,
   input  logic [ADDR_W-1:0] s0_arw_payload_addr,
   input  logic [1:0]        s0_arw_payload_burst,
   input  logic [UID_W-1:0]  s0_arw_payload_id,
   input  logic [LEN_W-1:0]  s0_arw_payload_len,
   input  logic [1:0]        s0_arw_payload_lock,
   input  logic [2:0]        s0_arw_payload_size,
   input  logic              s0_arw_payload_write,
   input  logic              s0_w_valid,
   output logic              s0_w_ready,
   input  logic [DATA_W-1:0] s0_w_payload_data,
   input  logic [STRB_W-1:0] s0_w_payload_strb,
   input  logic              s0_w_payload_last,
   output logic              s0_b_valid,
   input  logic              s0_b_ready,
   output logic [UID_W-1:0]  s0_b_payload_id,
   output logic              s0_r_valid,
   input  logic              s0_r_ready,
   output logic [DATA_W-1:0] s0_r_payload_data,
   output logic [UID_W-1:0]  s0_r_payload_id,
   output logic              s0_r_payload_last,
   output logic [1:0]        s0_r_payload_resp,

   input  logic              s1_arw_valid,
   output logic              s1_arw_ready,
   input  logic [ADDR_W-1:0] s1_arw_payload_addr,
   input  logic [1:0]        s1_arw_payload_burst,
   input  logic [UID_W-1:0]  s1_arw_payload_id,
   input  logic [LEN_W-1:0]  s1_arw_payload_len,
   input  logic [1:0]        s1_arw_payload_lock,
   input  logic [2:0]        s1_arw_payload_size,
   input  logic              s1_arw_payload_write,
   input  logic              s1_w_valid,
   output logic              s1_w_ready,
   input  logic [DATA_W-1:0] s1_w_payload_data,
   input  logic [STRB_W-1:0] s1_w_payload_strb,
   input  logic              s1_w_payload_last,
   output logic              s1_b_valid,
   input  logic              s1_b_ready,
   output logic [UID_W-1:0]  s1_b_payload_id,
   output logic              s1_r_valid,
   input  logic              s1_r_ready,
   output logic [DATA_W-1:0] s1_r_payload_data,
   output logic [UID_W-1:0]  s1_r_payload_id,
   output logic              s1_r_payload_last,
   output logic [1:0]        s1_r_payload_resp,

   output logic              io_ddrA_arw_valid,
   input  logic              io_ddrA_arw_ready,
   output logic [ADDR_W-1:0] io_ddrA_arw_payload_addr,
   output logic [1:0]        io_ddrA_arw_payload_burst,
   output logic [DID_W-1:0]  io_ddrA_arw_payload_id,
   output logic [LEN_W-1:0]  io_ddrA_arw_payload_len,
   output logic [1:0]        io_ddrA_arw_payload_lock,
   output logic [2:0]        io_ddrA_arw_payload_size,
   output logic              io_ddrA_arw_payload_write,
   output logic              io_ddrA_w_valid,
   input  logic              io_ddrA_w_ready,
   output logic [DID_W-1:0]  io_ddrA_w_payload_id,
   output logic [DATA_W-1:0] io_ddrA_w_payload_data,
   output logic [STRB_W-1:0] io_ddrA_w_payload_strb,
   output logic              io_ddrA_w_payload_last,
   input  logic              io_ddrA_b_valid,
   output logic              io_ddrA_b_ready,
   input  logic [DID_W-1:0]  io_ddrA_b_payload_id,
   input  logic              io_ddrA_r_valid,
   output logic              io_ddrA_r_ready,
   input  logic [DATA_W-1:0] io_ddrA_r_payload_data,
   input  logic [DID_W-1:0]  io_ddrA_r_payload_id,
   input  logic              io_ddrA_r_payload_last,
   input  logic [1:0]        io_ddrA_r_payload_resp
);

   arwPayload_t sArwPayload [2];
   logic [1:0]  sArwValid;
   logic [1:0]  sArwReady;
   logic [1:0]  sWValid;
   logic [1:0]  sWReady;
   logic [1:0]  sRValid;
   logic [1:0]  sRReady;
   logic [1:0]  sBValid;
   logic [1:0]  sBReady;
   logic [1:0]  eligible;

   arwPayload_t arwReg;
   logic        arwValidReg;
   logic        lastGrantReg;
   logic        canLoad;
   logic        grantValid;
   logic        grantPort;
   arwPayload_t grantPayload;

   logic [DID_W-1:0] fifoHead;
   logic             fifoFull;
   logic             fifoEmpty;
   logic             fifoPush;
   logic             fifoPop;
   logic             headPort;

   assign sArwValid = {s1_arw_valid, s0_arw_valid};
   assign sWValid   = {s1_w_valid, s0_w_valid};
   assign sRReady   = {s1_r_ready, s0_r_ready};
   assign sBReady   = {s1_b_ready, s0_b_ready};

   assign sArwPayload[0] = '{addr: s0_arw_payload_addr, burst: s0_arw_payload_burst,
                             id: makeDownId(1'b0, s0_arw_payload_id), len: s0_arw_payload_len,
                             lock: s0_arw_payload_lock, size: s0_arw_payload_size,
                             write: s0_arw_payload_write};
   assign sArwPayload[1] = '{addr: s1_arw_payload_addr, burst: s1_arw_payload_burst,
                             id: makeDownId(1'b1, s1_arw_payload_id), len: s1_arw_payload_len,
                             lock: s1_arw_payload_lock, size: s1_arw_payload_size,
                             write: s1_arw_payload_write};

   // A write waits for W-order space; a read never does, so one port cannot stall the other.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gPort
         assign eligible[gi]  = sArwValid[gi] && (!sArwPayload[gi].write || !fifoFull);
         assign sArwReady[gi] = grantValid && (grantPort == 1'(gi));
         assign sWReady[gi]   = !fifoEmpty && (headPort == 1'(gi)) && io_ddrA_w_ready;
         assign sRValid[gi]   = io_ddrA_r_valid && (io_ddrA_r_payload_id[DID_W-1] == 1'(gi));
         assign sBValid[gi]   = io_ddrA_b_valid && (io_ddrA_b_payload_id[DID_W-1] == 1'(gi));
      end
   endgenerate

   assign canLoad = !arwValidReg || io_ddrA_arw_ready;

`ifdef DDR_ARB_FIXED_PRIO_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starveCntReg;
   logic             starveHit;

   assign starveHit = (starveCntReg >= CNT_W'(STARVE_LIMIT));

   always_comb begin
      grantValid = canLoad && (|eligible);
      grantPort  = 1'b0;
      if (eligible[1] && (!eligible[0] || starveHit)) grantPort = 1'b1;
   end

   always_ff @(posedge io_memoryClk) begin
      if (!memoryClk_rstn) begin
         starveCntReg <= '0;
      end else if (grantValid && grantPort) begin
         starveCntReg <= '0;
      end else if (grantValid && eligible[1] && !starveHit) begin
         starveCntReg <= starveCntReg + CNT_W'(1);
      end
   end
`else
   // lastGrantReg=1 after reset so port 0 is preferred first.
   always_comb begin
      grantValid = canLoad && (|eligible);
      grantPort  = 1'b0;
      if (eligible[1] && (!eligible[0] || !lastGrantReg)) grantPort = 1'b1;
   end
`endif

   assign grantPayload = sArwPayload[grantPort];

   always_ff @(posedge io_memoryClk) begin
      if (!memoryClk_rstn) begin
         arwValidReg  <= 1'b0;
         arwReg       <= '0;
         lastGrantReg <= 1'b1;
      end else if (grantValid) begin
         arwValidReg  <= 1'b1;
         arwReg       <= grantPayload;
         lastGrantReg <= grantPort;
      end else if (io_ddrA_arw_ready) begin
         arwValidReg  <= 1'b0;
      end
   end

   assign fifoPush = grantValid && grantPayload.write;
   assign fifoPop  = io_ddrA_w_valid && io_ddrA_w_ready && io_ddrA_w_payload_last;

   ddr_arb_wfifo #(
      .DEPTH(WFIFO_DEPTH)
   ) uWfifo (
      .clk      (io_memoryClk),
      .rstn     (memoryClk_rstn),
      .push     (fifoPush),
      .pushData (grantPayload.id),
      .pop      (fifoPop),
      .headData (fifoHead),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   assign headPort = !fifoEmpty && fifoHead[DID_W-1];

   assign io_ddrA_arw_valid         = arwValidReg;
   assign io_ddrA_arw_payload_addr  = arwReg.addr;
   assign io_ddrA_arw_payload_burst = arwReg.burst;
   assign io_ddrA_arw_payload_id    = arwReg.id;
   assign io_ddrA_arw_payload_len   = arwReg.len;
   assign io_ddrA_arw_payload_lock  = arwReg.lock;
   assign io_ddrA_arw_payload_size  = arwReg.size;
   assign io_ddrA_arw_payload_write = arwReg.write;

   assign io_ddrA_w_valid        = !fifoEmpty && sWValid[headPort];
   assign io_ddrA_w_payload_id   = fifoEmpty ? '0 : fifoHead;
   assign io_ddrA_w_payload_data = headPort ? s1_w_payload_data : s0_w_payload_data;
   assign io_ddrA_w_payload_strb = headPort ? s1_w_payload_strb : s0_w_payload_strb;
   assign io_ddrA_w_payload_last = headPort ? s1_w_payload_last : s0_w_payload_last;

   assign s0_arw_ready = sArwReady[0];
   assign s1_arw_ready = sArwReady[1];
   assign s0_w_ready   = sWReady[0];
   assign s1_w_ready   = sWReady[1];

   assign io_ddrA_r_ready = sRReady[io_ddrA_r_payload_id[DID_W-1]];
   assign io_ddrA_b_ready = sBReady[io_ddrA_b_payload_id[DID_W-1]];

   assign s0_r_valid        = sRValid[0];
   assign s1_r_valid        = sRValid[1];
   assign s0_r_payload_data = io_ddrA_r_payload_data;
   assign s1_r_payload_data = io_ddrA_r_payload_data;
   assign s0_r_payload_id   = io_ddrA_r_payload_id[UID_W-1:0];
   assign s1_r_payload_id   = io_ddrA_r_payload_id[UID_W-1:0];
   assign s0_r_payload_last = io_ddrA_r_payload_last;
   assign s1_r_payload_last = io_ddrA_r_payload_last;
   assign s0_r_payload_resp = io_ddrA_r_payload_resp;
   assign s1_r_payload_resp = io_ddrA_r_payload_resp;

   assign s0_b_valid      = sBValid[0];
   assign s1_b_valid      = sBValid[1];
   assign s0_b_payload_id = io_ddrA_b_payload_id[UID_W-1:0];
   assign s1_b_payload_id = io_ddrA_b_payload_id[UID_W-1:0];

endmodule

// File: tb/tb_ddr_axi_arbiter2.sv
// Directed bench for ddr_axi_arbiter2: grant order, W ordering, FIFO full, backpressure, reset.
module tb_ddr_axi_arbiter2;

   logic          io_memoryClk = 1'b0;
   logic          memoryClk_rstn;

   logic          s0_arw_valid, s0_arw_ready;
   logic [31:0]   s0_arw_payload_addr;
   logic [1:0]    s0_arw_payload_burst;
   logic [6:0]    s0_arw_payload_id;
   logic [7:0]    s0_arw_payload_len;
   logic [1:0]    s0_arw_payload_lock;
   logic [2:0]    s0_arw_payload_size;
   logic          s0_arw_payload_write;
   logic          s0_w_valid, s0_w_ready;
   logic [127:0]  s0_w_payload_data;
   logic [15:0]   s0_w_payload_strb;
   logic          s0_w_payload_last;
   logic          s0_b_valid, s0_b_ready;
   logic [6:0]    s0_b_payload_id;
   logic          s0_r_valid, s0_r_ready;
   logic [127:0]  s0_r_payload_data;
   logic [6:0]    s0_r_payload_id;
   logic          s0_r_payload_last;
   logic [1:0]    s0_r_payload_resp;

   logic          s1_arw_valid, s1_arw_ready;
   logic [31:0]   s1_arw_payload_addr;
   logic [1:0]    s1_arw_payload_burst;
   logic [6:0]    s1_arw_payload_id;
   logic [7:0]    s1_arw_payload_len;
   logic [1:0]    s1_arw_payload_lock;
   logic [2:0]    s1_arw_payload_size;
   logic          s1_arw_payload_write;
   logic          s1_w_valid, s1_w_ready;
   logic [127:0]  s1_w_payload_data;
   logic [15:0]   s1_w_payload_strb;
   logic          s1_w_payload_last;
   logic          s1_b_valid, s1_b_ready;
   logic [6:0]    s1_b_payload_id;
   logic          s1_r_valid, s1_r_ready;
   logic [127:0]  s1_r_payload_data;
   logic [6:0]    s1_r_payload_id;
   logic          s1_r_payload_last;
   logic [1:0]    s1_r_payload_resp;

   logic          io_ddrA_arw_valid, io_ddrA_arw_ready;
   logic [31:0]   io_ddrA_arw_payload_addr;
   logic [1:0]    io_ddrA_arw_payload_burst;
   logic [7:0]    io_ddrA_arw_payload_id;
   logic [7:0]    io_ddrA_arw_payload_len;
   logic [1:0]    io_ddrA_arw_payload_lock;
   logic [2:0]    io_ddrA_arw_payload_size;
   logic          io_ddrA_arw_payload_write;
   logic          io_ddrA_w_valid, io_ddrA_w_ready;
   logic [7:0]    io_ddrA_w_payload_id;
   logic [127:0]  io_ddrA_w_payload_data;
   logic [15:0]   io_ddrA_w_payload_strb;
   logic          io_ddrA_w_payload_last;
   logic          io_ddrA_b_valid, io_ddrA_b_ready;
   logic [7:0]    io_ddrA_b_payload_id;
   logic          io_ddrA_r_valid, io_ddrA_r_ready;
   logic [127:0]  io_ddrA_r_payload_data;
   logic [7:0]    io_ddrA_r_payload_id;
   logic          io_ddrA_r_payload_last;
   logic [1:0]    io_ddrA_r_payload_resp;

   int checks = 0;
   int errors = 0;

   always #5 io_memoryClk = ~io_memoryClk;

   ddr_axi_arbiter2 #(.WFIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
      .io_memoryClk(io_memoryClk), .memoryClk_rstn(memoryClk_rstn),
      .s0_arw_valid(s0_arw_valid), .s0_arw_ready(s0_arw_ready),
      .s0_arw_payload_addr(s0_arw_payload_addr), .s0_arw_payload_burst(s0_arw_payload_burst),
      .s0_arw_payload_id(s0_arw_payload_id), .s0_arw_payload_len(s0_arw_payload_len),
      .s0_arw_payload_lock(s0_arw_payload_lock), .s0_arw_payload_size(s0_arw_payload_size),
      .s0_arw_payload_write(s0_arw_payload_write),
      .s0_w_valid(s0_w_valid), .s0_w_ready(s0_w_ready), .s0_w_payload_data(s0_w_payload_data),
      .s0_w_payload_strb(s0_w_payload_strb), .s0_w_payload_last(s0_w_payload_last),
      .s0_b_valid(s0_b_valid), .s0_b_ready(s0_b_ready), .s0_b_payload_id(s0_b_payload_id),
      .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready), .s0_r_payload_data(s0_r_payload_data),
      .s0_r_payload_id(s0_r_payload_id), .s0_r_payload_last(s0_r_payload_last),
      .s0_r_payload_resp(s0_r_payload_resp),
      .s1_arw_valid(s1_arw_valid), .s1_arw_ready(s1_arw_ready),
      .s1_arw_payload_addr(s1_arw_payload_addr), .s1_arw_payload_burst(s1_arw_payload_burst),
      .s1_arw_payload_id(s1_arw_payload_id), .s1_arw_payload_len(s1_arw_payload_len),
      .s1_arw_payload_lock(s1_arw_payload_lock), .s1_arw_payload_size(s1_arw_payload_size),
      .s1_arw_payload_write(s1_arw_payload_write),
      .s1_w_valid(s1_w_valid), .s1_w_ready(s1_w_ready), .s1_w_payload_data(s1_w_payload_data),
      .s1_w_payload_strb(s1_w_payload_strb), .s1_w_payload_last(s1_w_payload_last),
      .s1_b_valid(s1_b_valid), .s1_b_ready(s1_b_ready), .s1_b_payload_id(s1_b_payload_id),
      .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready), .s1_r_payload_data(s1_r_payload_data),
      .s1_r_payload_id(s1_r_payload_id), .s1_r_payload_last(s1_r_payload_last),
      .s1_r_payload_resp(s1_r_payload_resp),
      .io_ddrA_arw_valid(io_ddrA_arw_valid), .io_ddrA_arw_ready(io_ddrA_arw_ready),
      .io_ddrA_arw_payload_addr(io_ddrA_arw_payload_addr),
      .io_ddrA_arw_payload_burst(io_ddrA_arw_payload_burst),
      .io_ddrA_arw_payload_id(io_ddrA_arw_payload_id),
      .io_ddrA_arw_payload_len(io_ddrA_arw_payload_len),
      .io_ddrA_arw_payload_lock(io_ddrA_arw_payload_lock),
      .io_ddrA_arw_payload_size(io_ddrA_arw_payload_size),
      .io_ddrA_arw_payload_write(io_ddrA_arw_payload_write),
      .io_ddrA_w_valid(io_ddrA_w_valid), .io_ddrA_w_ready(io_ddrA_w_ready),
      .io_ddrA_w_payload_id(io_ddrA_w_payload_id), .io_ddrA_w_payload_data(io_ddrA_w_payload_data),
      .io_ddrA_w_payload_strb(io_ddrA_w_payload_strb), .io_ddrA_w_payload_last(io_ddrA_w_payload_last),
      .io_ddrA_b_valid(io_ddrA_b_valid), .io_ddrA_b_ready(io_ddrA_b_ready),
      .io_ddrA_b_payload_id(io_ddrA_b_payload_id),
      .io_ddrA_r_valid(io_ddrA_r_valid), .io_ddrA_r_ready(io_ddrA_r_ready),
      .io_ddrA_r_payload_data(io_ddrA_r_payload_data), .io_ddrA_r_payload_id(io_ddrA_r_payload_id),
      .io_ddrA_r_payload_last(io_ddrA_r_payload_last), .io_ddrA_r_payload_resp(io_ddrA_r_payload_resp)
   );

   task automatic step();
      @(posedge io_memoryClk);
      #1;
   endtask

   task automatic clear_inputs();
      s0_arw_valid = 0; s0_arw_payload_addr = '0; s0_arw_payload_burst = 2'd1; s0_arw_payload_id = '0;
      s0_arw_payload_len = '0; s0_arw_payload_lock = '0; s0_arw_payload_size = 3'd4; s0_arw_payload_write = 0;
      s1_arw_valid = 0; s1_arw_payload_addr = '0; s1_arw_payload_burst = 2'd1; s1_arw_payload_id = '0;
      s1_arw_payload_len = '0; s1_arw_payload_lock = '0; s1_arw_payload_size = 3'd4; s1_arw_payload_write = 0;
      s0_w_valid = 0; s0_w_payload_data = '0; s0_w_payload_strb = '1; s0_w_payload_last = 0;
      s1_w_valid = 0; s1_w_payload_data = '0; s1_w_payload_strb = '1; s1_w_payload_last = 0;
      s0_b_ready = 0; s1_b_ready = 0; s0_r_ready = 0; s1_r_ready = 0;
      io_ddrA_arw_ready = 0; io_ddrA_w_ready = 0;
      io_ddrA_b_valid = 0; io_ddrA_b_payload_id = '0;
      io_ddrA_r_valid = 0; io_ddrA_r_payload_data = '0; io_ddrA_r_payload_id = '0;
      io_ddrA_r_payload_last = 0; io_ddrA_r_payload_resp = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      memoryClk_rstn = 0;
      step();
      step();
      memoryClk_rstn = 1;
   endtask

   task automatic test_reset();
      do_reset();
      s0_w_valid = 1;
      @(negedge io_memoryClk);
      checks++; if (io_ddrA_arw_valid !== 1'b0) begin errors++; $display("FAIL reset_arw_valid got %0b exp 0", io_ddrA_arw_valid); end
      checks++; if (io_ddrA_arw_payload_addr !== 32'h0 || io_ddrA_arw_payload_id !== 8'h0) begin errors++;
         $display("FAIL reset_arw_payload got addr %h id %h exp 0", io_ddrA_arw_payload_addr, io_ddrA_arw_payload_id); end
      checks++; if (io_ddrA_w_valid !== 1'b0 || s0_w_ready !== 1'b0 || s1_w_ready !== 1'b0) begin errors++;
         $display("FAIL reset_w got w_valid %0b s0_w_ready %0b s1_w_ready %0b exp 0", io_ddrA_w_valid, s0_w_ready, s1_w_ready); end
      checks++; if (s0_arw_ready !== 1'b0 || s1_arw_ready !== 1'b0) begin errors++;
         $display("FAIL reset_arw_ready got %0b%0b exp 00", s1_arw_ready, s0_arw_ready); end
      $display("test_reset done");
      step();
      clear_inputs();
   endtask

   task automatic test_read_port0();
      do_reset();
      io_ddrA_arw_ready = 1;
      s0_arw_valid = 1; s0_arw_payload_addr = 32'h1000; s0_arw_payload_len = 8'd3; s0_arw_payload_id = 7'h05;
      @(negedge io_memoryClk);
      checks++; if (s0_arw_ready !== 1'b1 || io_ddrA_arw_valid !== 1'b0) begin errors++;
         $display("FAIL rd_grant got s0_arw_ready %0b arw_valid %0b exp 1 0", s0_arw_ready, io_ddrA_arw_valid); end
      step();
      s0_arw_valid = 0;
      @(negedge io_memoryClk);
      checks++; if (io_ddrA_arw_valid !== 1'b1 || io_ddrA_arw_payload_id !== 8'h05 ||
                    io_ddrA_arw_payload_addr !== 32'h1000 || io_ddrA_arw_payload_len !== 8'd3 ||
                    io_ddrA_arw_payload_write !== 1'b0) begin errors++;
         $display("FAIL rd_arw_out got v %0b id %h addr %h len %0d wr %0b exp 1 05 1000 3 0", io_ddrA_arw_valid,
                  io_ddrA_arw_payload_id, io_ddrA_arw_payload_addr, io_ddrA_arw_payload_len, io_ddrA_arw_payload_write); end
      for (int b = 0; b < 4; b++) begin
         step();
         io_ddrA_r_valid = 1; io_ddrA_r_payload_id = 8'h05; io_ddrA_r_payload_data = 128'hA0 + 128'(b);
         io_ddrA_r_payload_last = (b == 3); s0_r_ready = 1;
         @(negedge io_memoryClk);
         checks++; if (s0_r_valid !== 1'b1 || s0_r_payload_id !== 7'h05 || s0_r_payload_last !== (b == 3) ||
                       s0_r_payload_data !== 128'hA0 + 128'(b) || s1_r_valid !== 1'b0 || io_ddrA_r_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_beat%0d got s0v %0b id %h last %0b data %h s1v %0b rr %0b", b, s0_r_valid,
                     s0_r_payload_id, s0_r_payload_last, s0_r_payload_data, s1_r_valid, io_ddrA_r_ready);
         end
         $display("read beat %0d id %h last %0b", b, s0_r_payload_id, s0_r_payload_last);
      end
      checks++; if (io_ddrA_arw_valid !== 1'b0) begin errors++; $display("FAIL rd_arw_drained got %0b exp 0", io_ddrA_arw_valid); end
      step();
      clear_inputs();
   endtask

   task automatic test_simultaneous_writes();
      do_reset();
      io_ddrA_arw_ready = 1;
      s0_arw_valid = 1; s0_arw_payload_write = 1; s0_arw_payload_id = 7'h02; s0_arw_payload_addr = 32'h2000;
      s1_arw_valid = 1; s1_arw_payload_write = 1; s1_arw_payload_id = 7'h03; s1_arw_payload_addr = 32'h3000;
      @(negedge io_memoryClk);
      checks++; if (s0_arw_ready !== 1'b1 || s1_arw_ready !== 1'b0) begin errors++;
         $display("FAIL wr_first_grant got s0 %0b s1 %0b exp 1 0", s0_arw_ready, s1_arw_ready); end
      step();
      s0_arw_valid = 0;
      @(negedge io_memoryClk);
      checks++; if (s1_arw_ready !== 1'b1 || io_ddrA_arw_payload_id !== 8'h02 || io_ddrA_arw_payload_write !== 1'b1) begin errors++;
         $display("FAIL wr_second_grant got s1 %0b arw id %h wr %0b exp 1 02 1", s1_arw_ready, io_ddrA_arw_payload_id, io_ddrA_arw_payload_write); end
      step();
      s1_arw_valid = 0;
      @(negedge io_memoryClk);
      checks++; if (io_ddrA_arw_payload_id !== 8'h83 || io_ddrA_arw_payload_addr !== 32'h3000) begin errors++;
         $display("FAIL wr_arw_port1 got id %h addr %h exp 83 3000", io_ddrA_arw_payload_id, io_ddrA_arw_payload_addr); end
      step();
      io_ddrA_w_ready = 1;
      s0_w_valid = 1; s0_w_payload_data = 128'hD0; s0_w_payload_last = 1;
      s1_w_valid = 1; s1_w_payload_data = 128'hD1; s1_w_payload_last = 1;
      @(negedge io_memoryClk);
      checks++; if (io_ddrA_w_valid !== 1'b1 || io_ddrA_w_payload_id !== 8'h02 || io_ddrA_w_payload_data !== 128'hD0 ||
                    s0_w_ready !== 1'b1 || s1_w_ready !== 1'b0) begin errors++;
         $display("FAIL w_first got v %0b id %h data %h rdy %0b%0b exp 1 02 d0 01", io_ddrA_w_valid,
                  io_ddrA_w_payload_id, io_ddrA_w_payload_data, s1_w_ready, s0_w_ready); end
      $display("w beat id %h", io_ddrA_w_payload_id);
      step();
      s0_w_valid = 0;
      @(negedge io_memoryClk);
      checks++; if (io_ddrA_w_valid !== 1'b1 || io_ddrA_w_payload_id !== 8'h83 || io_ddrA_w_payload_data !== 128'hD1 ||
                    s1_w_ready !== 1'b1 || s0_w_ready !== 1'b0) begin errors++;
         $display("FAIL w_second got v %0b id %h data %h rdy %0b%0b exp 1 83 d1 10", io_ddrA_w_valid,
                  io_ddrA_w_payload_id, io_ddrA_w_payload_data, s1_w_ready, s0_w_ready); end
      $display("w beat id %h", io_ddrA_w_payload_id);
      step();
      s1_w_valid = 0; s0_w_valid = 1;
      @(negedge io_memoryClk);
      checks++; if (io_ddrA_w_valid !== 1'b0 || s0_w_ready !== 1'b0) begin errors++;
         $display("FAIL w_empty got v %0b s0_w_ready %0b exp 0 0", io_ddrA_w_valid, s0_w_ready); end
      step();
      s0_w_valid = 0;
      io_ddrA_b_valid = 1; io_ddrA_b_payload_id = 8'h83; s1_b_ready = 1; s0_b_ready = 0;
      @(negedge io_memoryClk);
      checks++; if (s1_b_valid !== 1'b1 || s1_b_payload_id !== 7'h03 || s0_b_valid !== 1'b0 || io_ddrA_b_ready !== 1'b1) begin errors++;
         $display("FAIL b_route got s1v %0b id %h s0v %0b bready %0b exp 1 03 0 1", s1_b_valid, s1_b_payload_id,
                  s0_b_valid, io_ddrA_b_ready); end
      $display("b response id %h to port 1", s1_b_payload_id);
      step();
      clear_inputs();
   endtask

   task automatic test_fifo_full();
      do_reset();
      io_ddrA_arw_ready = 1;
      s0_arw_valid = 1; s0_arw_payload_write = 1;
      for (int k = 0; k < 4; k++) begin
         s0_arw_payload_id = 7'(8'h10 + k);
         @(negedge io_memoryClk);
         checks++; if (s0_arw_ready !== 1'b1) begin errors++; $display("FAIL full_fill%0d got %0b exp 1", k, s0_arw_ready); end
         $display("write %0d granted", k);
         step();
      end
      s0_arw_payload_id = 7'h14;
      @(negedge io_memoryClk);
      checks++; if (s0_arw_ready !== 1'b0) begin errors++; $display("FAIL full_block got %0b exp 0", s0_arw_ready); end
      step();
      s1_arw_valid = 1; s1_arw_payload_id = 7'h20;
      @(negedge io_memoryClk);
      checks++; if (s0_arw_ready !== 1'b0 || s1_arw_ready !== 1'b1) begin errors++;
         $display("FAIL full_read_pass got s0 %0b s1 %0b exp 0 1", s0_arw_ready, s1_arw_ready); end
      step();
      s1_arw_valid = 0;
      io_ddrA_w_ready = 1; s0_w_valid = 1; s0_w_payload_last = 1;
      @(negedge io_memoryClk);
      checks++; if (s0_arw_ready !== 1'b0 || s0_w_ready !== 1'b1 || io_ddrA_w_payload_id !== 8'h10) begin errors++;
         $display("FAIL full_pop_cycle got arw_rdy %0b w_rdy %0b wid %h exp 0 1 10", s0_arw_ready, s0_w_ready, io_ddrA_w_payload_id); end
      step();
      s0_w_valid = 0;
      @(negedge io_memoryClk);
      checks++; if (s0_arw_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop got %0b exp 1", s0_arw_ready); end
      step();
      clear_inputs();
   endtask

   task automatic test_backpressure();
      logic expS1;
      do_reset();
      s0_arw_valid = 1; s0_arw_payload_id = 7'h11; s0_arw_payload_addr = 32'hAAAA_0000;
      s1_arw_valid = 1; s1_arw_payload_id = 7'h22; s1_arw_payload_addr = 32'hBBBB_0000;
      @(negedge io_memoryClk);
      checks++; if (s0_arw_ready !== 1'b1 || s1_arw_ready !== 1'b0) begin errors++;
         $display("FAIL bp_first got s0 %0b s1 %0b exp 1 0", s0_arw_ready, s1_arw_ready); end
      step();
      for (int c = 0; c < 5; c++) begin
         @(negedge io_memoryClk);
         checks++; if (io_ddrA_arw_valid !== 1'b1 || io_ddrA_arw_payload_id !== 8'h11 ||
                       io_ddrA_arw_payload_addr !== 32'hAAAA_0000 || s0_arw_ready !== 1'b0 || s1_arw_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got v %0b id %h addr %h rdy %0b%0b", c, io_ddrA_arw_valid,
                     io_ddrA_arw_payload_id, io_ddrA_arw_payload_addr, s1_arw_ready, s0_arw_ready);
         end
         $display("stall cycle %0d arw id %h", c, io_ddrA_arw_payload_id);
         step();
      end
      io_ddrA_arw_ready = 1;
`ifdef DDR_ARB_FIXED_PRIO_EN
      expS1 = 1'b0;
`else
      expS1 = 1'b1;
`endif
      @(negedge io_memoryClk);
      checks++; if (s1_arw_ready !== expS1 || s0_arw_ready !== !expS1) begin errors++;
         $display("FAIL bp_release got s0 %0b s1 %0b exp s1=%0b", s0_arw_ready, s1_arw_ready, expS1); end
      step();
      @(negedge io_memoryClk);
      checks++; if (io_ddrA_arw_payload_id !== (expS1 ? 8'hA2 : 8'h11)) begin errors++;
         $display("FAIL bp_next_id got %h exp %h", io_ddrA_arw_payload_id, expS1 ? 8'hA2 : 8'h11); end
      step();
      clear_inputs();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      io_ddrA_arw_ready = 1;
      s0_arw_valid = 1; s0_arw_payload_write = 1; s0_arw_payload_id = 7'h01; s0_arw_payload_len = 8'd3;
      step();
      s0_arw_valid = 0; io_ddrA_arw_ready = 0;
      io_ddrA_w_ready = 1; s0_w_valid = 1; s0_w_payload_last = 0;
      @(negedge io_memoryClk);
      checks++; if (io_ddrA_w_valid !== 1'b1 || io_ddrA_arw_valid !== 1'b1) begin errors++;
         $display("FAIL mid_beat1 got w_valid %0b arw_valid %0b exp 1 1", io_ddrA_w_valid, io_ddrA_arw_valid); end
      step();
      memoryClk_rstn = 0;
      step();
      @(negedge io_memoryClk);
      checks++; if (io_ddrA_arw_valid !== 1'b0 || io_ddrA_w_valid !== 1'b0 || s0_w_ready !== 1'b0) begin errors++;
         $display("FAIL mid_reset got arw_v %0b w_v %0b s0_w_ready %0b exp 0 0 0", io_ddrA_arw_valid, io_ddrA_w_valid, s0_w_ready); end
      memoryClk_rstn = 1;
      step();
      @(negedge io_memoryClk);
      checks++; if (io_ddrA_w_valid !== 1'b0) begin errors++; $display("FAIL mid_after got w_valid %0b exp 0", io_ddrA_w_valid); end
      $display("test_reset_mid_burst done");
      step();
      clear_inputs();
   endtask

   task automatic test_grant_sequence();
      logic exp1;
      do_reset();
      io_ddrA_arw_ready = 1;
      s0_arw_valid = 1; s0_arw_payload_id = 7'h0A;
      s1_arw_valid = 1; s1_arw_payload_id = 7'h0B;
      for (int k = 1; k <= 18; k++) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
         exp1 = ((k % 9) == 0);
`else
         exp1 = ((k % 2) == 0);
`endif
         @(negedge io_memoryClk);
         checks++; if (s1_arw_ready !== exp1 || s0_arw_ready !== !exp1) begin errors++;
            $display("FAIL grant%0d got s0 %0b s1 %0b exp s1=%0b", k, s0_arw_ready, s1_arw_ready, exp1); end
         $display("grant %0d to port %0d", k, s1_arw_ready);
         step();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      memoryClk_rstn = 0;
      test_reset();
      test_read_port0();
      test_simultaneous_writes();
      test_fifo_full();
      test_backpressure();
      test_reset_mid_burst();
      test_grant_sequence();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
